fifo_wr_ctrl: RTL and testbench

//  Write-side controller for the async FIFO memory (write domain, W_CLK).
//  - Gates writer requests into the memory write enable and owns the write address.
//  - Exports a Gray-coded write pointer to the read domain.
//  - Synchronises the read domain's Gray pointer.
//  - Produces full, almost-full, fill-level and sticky-overflow status for the writer.

---
 rtl/fifo_wr_ctrl_pkg.sv | 26 ++
 rtl/fifo_wr_ctrl_sync.sv | 27 ++
 rtl/fifo_wr_ctrl.sv | 83 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared async-FIFO helpers, used by both the write- and read-side controllers.
//  - ADDR_WIDTH_DEF / PTR_WIDTH : default address width and pointer width (one wrap bit extra)
//  - bin2gray / gray2bin        : pointer code conversion on a wide, zero-extended vector;
//                                 callers size-cast the result back to their pointer width
package fifo_wr_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 3;
    localparam int PTR_WIDTH      = ADDR_WIDTH_DEF + 1;
    localparam int CONV_WIDTH     = 16;

    typedef logic [CONV_WIDTH-1:0] conv_t;

    function automatic conv_t bin2gray(input conv_t b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros from zero-extension leave the low bits' result untouched.
    function automatic conv_t gray2bin(input conv_t g);
        conv_t b;
        b[CONV_WIDTH-1] = g[CONV_WIDTH-1];
        for (int i = CONV_WIDTH - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
//  gclk   : destination clock
//  grst_n : async active-low reset, clears both stages
//  d      : asynchronous input
//  q      : synchronised output (second stage)
module ptr_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO (W_CLK domain).
//  W_CLK, W_RST   : clock, async active-low reset
//  W_INC, W_DATA  : producer push request and data
//  R_PTR_GRAY     : read pointer (Gray) from the read domain, asynchronous
//  W_CLK_EN       : memory write enable (push accepted this edge)
//  W_ADDR         : memory write address
//  W_DATA_MEM     : data to memory (pass-through)
//  W_PTR_GRAY     : registered Gray write pointer to the read domain
//  W_FULL/W_AFULL : full / almost-full status (registered)
//  W_LEVEL        : fill level 0..MEM_DEPTH as seen from the write side (registered)
//  W_OVF          : sticky, a push was attempted while full
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int MEM_DEPTH    = 2 ** ADDR_WIDTH,
    parameter int AFULL_THRESH = MEM_DEPTH - 2
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    input  logic [ADDR_WIDTH:0]   R_PTR_GRAY,
    output logic                  W_CLK_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [DATA_WIDTH-1:0] W_DATA_MEM,
    output logic [ADDR_WIDTH:0]   W_PTR_GRAY,
    output logic                  W_FULL,
    output logic                  W_AFULL,
    output logic [ADDR_WIDTH:0]   W_LEVEL,
    output logic                  W_OVF
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin, wbin_next, wgray_next;
    logic [PW-1:0] rq2, rbin, full_gray, level_next;

    ptr_sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .gclk   (W_CLK),
        .grst_n (W_RST),
        .d      (R_PTR_GRAY),
        .q      (rq2)
    );

    assign W_CLK_EN   = W_INC & ~W_FULL;
    assign W_ADDR     = wbin[ADDR_WIDTH-1:0];
    assign W_DATA_MEM = W_DATA;

    assign wbin_next  = wbin + PW'(W_CLK_EN);
    assign wgray_next = PW'(bin2gray(CONV_WIDTH'(wbin_next)));
    assign rbin       = PW'(gray2bin(CONV_WIDTH'(rq2)));

    // Full when the write pointer sits exactly one lap ahead of the read
    // pointer: in Gray code that is the top two bits inverted, rest equal.
    assign full_gray  = {~rq2[PW-1:PW-2], rq2[PW-3:0]};

    // Computed from the stale synchronised read pointer, so it can only
    // overstate occupancy.
    assign level_next = wbin_next - rbin;

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wbin       <= '0;
            W_PTR_GRAY <= '0;
            W_FULL     <= 1'b0;
            W_AFULL    <= 1'b0;
            W_LEVEL    <= '0;
            W_OVF      <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            W_PTR_GRAY <= wgray_next;
            W_FULL     <= (wgray_next == full_gray);
            W_AFULL    <= (level_next >= AFULL_T);
            W_LEVEL    <= level_next;
            if (W_INC && W_FULL)
                W_OVF <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// A behavioural occupancy model predicts the registered outputs of each
// cycle; predictions are queued when a cycle is driven and popped after
// the clock edge for comparison.
module tb_fifo_wr_ctrl;

    logic       W_CLK = 1'b0;
    logic       W_RST = 1'b0;
    logic       W_INC = 1'b0;
    logic [7:0] W_DATA = '0;
    logic [3:0] R_PTR_GRAY = '0;
    logic       W_CLK_EN;
    logic [2:0] W_ADDR;
    logic [7:0] W_DATA_MEM;
    logic [3:0] W_PTR_GRAY;
    logic       W_FULL, W_AFULL, W_OVF;
    logic [3:0] W_LEVEL;

    fifo_wr_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .W_CLK(W_CLK), .W_RST(W_RST), .W_INC(W_INC), .W_DATA(W_DATA),
        .R_PTR_GRAY(R_PTR_GRAY), .W_CLK_EN(W_CLK_EN), .W_ADDR(W_ADDR),
        .W_DATA_MEM(W_DATA_MEM), .W_PTR_GRAY(W_PTR_GRAY), .W_FULL(W_FULL),
        .W_AFULL(W_AFULL), .W_LEVEL(W_LEVEL), .W_OVF(W_OVF)
    );

    always #5 W_CLK = ~W_CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int gray; int full; int afull; int level; int ovf; int addr;
    } exp_t;
    exp_t sbq[$];

    // Model: write count, two-stage view of the remote pointer, status.
    int m_wbin, m_rq1, m_rq2, m_full, m_ovf;

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int g2b(input int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
    endfunction

    task automatic m_reset();
        m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0; m_ovf = 0;
        sbq.delete();
    endtask

    // Called at a negedge: drive, check combinational outputs, predict, clock, compare.
    task automatic step(input logic inc, input logic [7:0] d, input logic [3:0] rp);
        exp_t e, o;
        int en, wn, lvl;
        W_INC = inc; W_DATA = d; R_PTR_GRAY = rp;
        #1;
        en = (inc && m_full == 0) ? 1 : 0;
        chk("clk_en", W_CLK_EN, en);
        chk("addr", W_ADDR, m_wbin % 8);
        chk("data_mem", W_DATA_MEM, d);
        wn  = (m_wbin + en) % 16;
        lvl = (wn - g2b(m_rq2)) & 15;
        if (inc && m_full != 0) m_ovf = 1;
        e.gray  = b2g(wn);
        e.level = lvl;
        e.full  = (lvl == 8) ? 1 : 0;
        e.afull = (lvl >= 6) ? 1 : 0;
        e.ovf   = m_ovf;
        e.addr  = wn % 8;
        sbq.push_back(e);
        m_full = e.full; m_rq2 = m_rq1; m_rq1 = rp; m_wbin = wn;
        @(posedge W_CLK); #1;
        o = sbq.pop_front();
        chk("ptr_gray", W_PTR_GRAY, o.gray);
        chk("full", W_FULL, o.full);
        chk("afull", W_AFULL, o.afull);
        chk("level", W_LEVEL, o.level);
        chk("ovf", W_OVF, o.ovf);
        chk("addr_post", W_ADDR, o.addr);
        @(negedge W_CLK);
    endtask

    // Asserted at a negedge; registered outputs must clear without a clock edge.
    task automatic do_reset(input logic inc);
        W_INC = inc; W_RST = 1'b0;
        #1;
        m_reset();
        chk("rst_gray", W_PTR_GRAY, 0);
        chk("rst_full", W_FULL, 0);
        chk("rst_afull", W_AFULL, 0);
        chk("rst_level", W_LEVEL, 0);
        chk("rst_ovf", W_OVF, 0);
        chk("rst_addr", W_ADDR, 0);
        chk("rst_clk_en", W_CLK_EN, inc);
        @(negedge W_CLK);
        W_INC = 1'b0; W_RST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gtab [8];
        int wcnt;
        gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

        @(negedge W_CLK);
        do_reset(1'b0);

        // 1: idle after reset
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 4'h0);
        chk("t1_gray", W_PTR_GRAY, 0);
        chk("t1_level", W_LEVEL, 0);

        // 2: fill to full
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h10 + i), 4'h0);
            chk("t2_gray", W_PTR_GRAY, gtab[i]);
            if (i == 4) chk("t2_afull_p5", W_AFULL, 0);
            if (i == 5) chk("t2_afull_p6", W_AFULL, 1);
        end
        chk("t2_full", W_FULL, 1);
        chk("t2_level", W_LEVEL, 8);

        // 3: push while full
        step(1'b1, 8'hA5, 4'h0);
        chk("t3_ovf", W_OVF, 1);
        chk("t3_addr", W_ADDR, 0);
        chk("t3_full", W_FULL, 1);

        // 4: remote pop of one entry, seen on the third edge
        step(1'b0, 8'h00, 4'h1);
        chk("t4_full_e1", W_FULL, 1);
        step(1'b0, 8'h00, 4'h1);
        chk("t4_full_e2", W_FULL, 1);
        chk("t4_level_e2", W_LEVEL, 8);
        step(1'b0, 8'h00, 4'h1);
        chk("t4_full_e3", W_FULL, 0);
        chk("t4_level_e3", W_LEVEL, 7);
        step(1'b1, 8'h3C, 4'h1);
        chk("t4_refill", W_FULL, 1);

        // 5: wrap with a reader trailing two entries behind
        do_reset(1'b0);
        wcnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'(k), 4'(b2g((wcnt >= 2) ? wcnt - 2 : 0)));
            wcnt++;
            chk("t5_never_full", W_FULL, 0);
            if (k == 7)  chk("t5_msb_8", W_PTR_GRAY[3], 1);
            if (k == 15) chk("t5_msb_16", W_PTR_GRAY[3], 0);
        end

        // 6: reset mid-burst at level 5
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h50 + k), 4'h0);
        chk("t6_level5", W_LEVEL, 5);
        do_reset(1'b1);
        step(1'b1, 8'h77, 4'h0);
        chk("t6_ovf", W_OVF, 0);
        chk("t6_gray", W_PTR_GRAY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
